// File: rtl/time_counter_pkg.sv
// time_counter_pkg: shared types for the time counter and its prescaler
package time_counter_pkg;
   typedef enum logic {MODE_WRAP, MODE_SAT} mode_e;
endpackage

// File: rtl/time_counter_gen_tick_gen.sv
// tick_gen: emits one tick for every DIV enabled cycles; collapses to a wire for DIV=1
module tick_gen #(
   parameter int DIV = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic sync_clr_i,
   output logic tick_o
);
   if (DIV < 1) begin : g_bad
      $error("tick_gen: DIV must be >= 1");
   end else if (DIV == 1) begin : g_pass
      logic unused;
      assign unused = ^{clk_i, rst_i, sync_clr_i};
      assign tick_o = en_i;
   end else begin : g_div
      localparam int CW = $clog2(DIV);
      localparam logic [CW-1:0] LAST = CW'(DIV - 1);
      logic [CW-1:0] pre;
      assign tick_o = en_i && pre == LAST;
      always_ff @(posedge clk_i or posedge rst_i)
         if (rst_i) pre <= '0;
         else if (sync_clr_i) pre <= '0;
         else if (en_i) pre <= tick_o ? '0 : pre + CW'(1);
   end
endmodule

// File: rtl/time_counter_gen.sv
// time_counter_gen: prescaled up/down counter with clear, load, wrap or saturate, and terminal-count pulse
module time_counter_gen
   import time_counter_pkg::*;
#(
   parameter int     WIDTH     = 5,
   parameter longint MAX_COUNT = (longint'(1) << WIDTH) - 1,
   parameter int     DIV       = 1,
   parameter mode_e  MODE      = MODE_WRAP
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             up_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o,
   output logic             at_term_o
);
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("time_counter_gen: WIDTH must be 1..32");
   end
   if (MAX_COUNT <= 0 || MAX_COUNT >= (longint'(1) << WIDTH)) begin : g_bad_max
      $error("time_counter_gen: MAX_COUNT must be 1..2**WIDTH-1");
   end
   if (DIV < 1) begin : g_bad_div
      $error("time_counter_gen: DIV must be >= 1");
   end
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
   logic             tick;
   logic             at_bound;
   logic             moved;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] stepped;
   tick_gen #(.DIV(DIV)) u_tick (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .sync_clr_i(clr_i | load_i),
      .tick_o    (tick)
   );
   // a saturating step at the boundary leaves the count unchanged and must not pulse tc_o
   always_comb begin
      term     = up_i ? MAX : '0;
      at_bound = count_o == term;
      stepped  = at_bound ? (MODE == MODE_WRAP ? (up_i ? '0 : MAX) : count_o)
                          : (up_i ? count_o + WIDTH'(1) : count_o - WIDTH'(1));
      moved    = !(at_bound && MODE == MODE_SAT);
   end
   assign at_term_o = at_bound;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         count_o <= '0;
         tc_o    <= 1'b0;
      end else if (clr_i) begin
         count_o <= '0;
         tc_o    <= 1'b0;
      end else if (load_i) begin
         count_o <= load_val_i > MAX ? MAX : load_val_i;
         tc_o    <= 1'b0;
      end else begin
         if (tick) count_o <= stepped;
         tc_o <= tick && moved && stepped == term;
      end
endmodule

// File: tb/tb_time_counter_gen.sv
// tb_time_counter_gen: four counter configurations on shared random stimulus, checked against an arithmetic model
module tb_time_counter_gen;
   import time_counter_pkg::*;
   localparam int NC = 4;
   function automatic int cw(int g); return g == 0 ? 5 : (g == 3 ? 3 : 4); endfunction
   function automatic int cm(int g); return g == 0 ? 31 : (g == 3 ? 7 : 9); endfunction
   function automatic int cd(int g); return g == 1 ? 4 : (g == 2 ? 3 : 1); endfunction
   function automatic bit cs(int g); return g == 1 || g == 3; endfunction
   function automatic int nxt(int c, int m, bit sat, bit u);
      int s;
      s = u ? c + 1 : c - 1;
      return sat ? (s < 0 ? 0 : (s > m ? m : s)) : (s + m + 1) % (m + 1);
   endfunction

   logic clk = 0, rst = 1, en = 0, up = 1, clr = 0, load = 0;
   logic [4:0] lv = '0;
   logic [4:0] act_cnt [NC];
   logic       act_tc  [NC];
   logic       act_at  [NC];
   int mc [NC];
   int mp [NC];
   bit mt [NC];
   int n_cmp = 0, n_bad = 0;
   int p0, p1, p3;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NC; g++) begin : g_dut
      localparam int W = cw(g);
      logic [W-1:0] cnt;
      time_counter_gen #(
         .WIDTH(W), .MAX_COUNT(cm(g)), .DIV(cd(g)), .MODE(cs(g) ? MODE_SAT : MODE_WRAP)
      ) u_dut (
         .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clr_i(clr), .load_i(load),
         .load_val_i(lv[W-1:0]), .count_o(cnt), .tc_o(act_tc[g]), .at_term_o(act_at[g])
      );
      assign act_cnt[g] = 5'(cnt);
   end

   // model: counts enabled cycles since the last step; every DIV-th one moves the count
   always @(posedge clk or posedge rst) begin
      for (int g = 0; g < NC; g++) begin
         int n, v;
         if (rst || clr) begin
            mc[g] <= 0; mp[g] <= 0; mt[g] <= 0;
         end else if (load) begin
            v = int'(lv) & ((1 << cw(g)) - 1);
            mc[g] <= v > cm(g) ? cm(g) : v; mp[g] <= 0; mt[g] <= 0;
         end else if (en && mp[g] == cd(g) - 1) begin
            n = nxt(mc[g], cm(g), cs(g), up);
            mc[g] <= n; mp[g] <= 0;
            mt[g] <= n != mc[g] && n == (up ? cm(g) : 0);
         end else begin
            mt[g] <= 0;
            if (en) mp[g] <= mp[g] + 1;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endtask

   task automatic step(input logic e_, input logic u_, input logic c_, input logic l_, input logic [4:0] v_);
      en = e_; up = u_; clr = c_; load = l_; lv = v_;
      @(posedge clk); #1;
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            for (int g = 0; g < NC; g++) begin
               check($sformatf("cnt%0d", g), act_cnt[g], mc[g]);
               check($sformatf("tc%0d", g), act_tc[g], mt[g]);
               check($sformatf("at%0d", g), act_at[g], mc[g] == (up ? cm(g) : 0));
            end
         end
      join_none
      repeat (2) @(posedge clk);
      #1;
      check("rst_cnt0", act_cnt[0], 0);
      check("rst_tc0", act_tc[0], 0);
      // wrap-up run from reset, 33 enabled cycles
      rst = 0; p0 = 0; p3 = 0;
      for (int i = 0; i < 33; i++) begin
         step(1, 1, 0, 0, 0);
         p0 += int'(act_tc[0]); p3 += int'(act_tc[3]);
         if (i == 30) begin
            check("up_at31_cnt", act_cnt[0], 31);
            check("up_at31_tc", act_tc[0], 1);
         end
      end
      check("up_final_cnt0", act_cnt[0], 1);
      check("up_tc_pulses0", p0, 1);
      check("sat_final_cnt3", act_cnt[3], 7);
      check("sat_tc_pulses3", p3, 1);
      check("div4_final_cnt1", act_cnt[1], 8);
      check("div3_final_cnt2", act_cnt[2], 1);
      // load clamps, clear beats load
      step(0, 1, 0, 1, 15);
      check("load_clamp1", act_cnt[1], 9);
      check("load_clamp2", act_cnt[2], 9);
      step(0, 1, 1, 1, 15);
      check("clr_wins1", act_cnt[1], 0);
      // saturating down count with prescale 4
      step(0, 0, 0, 1, 2);
      p1 = 0;
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 0, 0, 0);
         p1 += int'(act_tc[1]);
         if (i == 3) check("down_step1", act_cnt[1], 1);
         if (i == 7) begin
            check("down_step0", act_cnt[1], 0);
            check("down_tc", act_tc[1], 1);
         end
      end
      check("down_hold0", act_cnt[1], 0);
      check("down_tc_pulses", p1, 1);
      // direction toggled every tick, then frozen
      step(0, 1, 0, 1, 5);
      p0 = 0;
      for (int i = 0; i < 4; i++) begin
         step(1, i % 2 == 0, 0, 0, 0);
         p0 += int'(act_tc[0]);
         if (i == 0) check("toggle_first", act_cnt[0], 6);
      end
      check("toggle_cnt", act_cnt[0], 5);
      check("toggle_no_tc", p0, 0);
      repeat (3) step(0, 1'($urandom), 0, 0, 0);
      check("frozen_cnt", act_cnt[0], 5);
      // async reset with a partially filled prescaler
      step(0, 1, 0, 1, 7);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check("pre_rst_cnt2", act_cnt[2], 7);
      #2 rst = 1;
      #1 check("async_rst_cnt2", act_cnt[2], 0);
      @(posedge clk); #1;
      rst = 0;
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check("post_rst_wait", act_cnt[2], 0);
      step(1, 1, 0, 0, 0);
      check("post_rst_first", act_cnt[2], 1);
      // random traffic
      repeat (3000) begin
         int r;
         r = int'($urandom_range(0, 99));
         rst = r < 1;
         step($urandom_range(0, 4) != 0, 1'($urandom), r >= 1 && r < 5, r >= 5 && r < 12, 5'($urandom));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/time_counter_gen.md
TIME_COUNTER_GEN -- requirements
Module: time_counter_gen

Interface
REQ-001 Parameter WIDTH, default 5, counter width in bits (1..32).
REQ-002 Parameter MAX_COUNT, default 2**WIDTH-1, terminal value; elaboration SHALL fail if MAX_COUNT >= 2**WIDTH or MAX_COUNT = 0.
REQ-003 Parameter DIV, default 1, prescale ratio: one counting step per DIV enabled cycles; elaboration SHALL fail if DIV < 1.
REQ-004 Parameter MODE, default MODE_WRAP, boundary behaviour, of type mode_e (MODE_WRAP or MODE_SAT).
REQ-005 clk_i  input  1  the single clock, rising-edge active.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 en_i  input  1  counting enable; low freezes both the count and the prescaler.
REQ-008 up_i  input  1  direction: 1 counts up, 0 counts down.
REQ-009 clr_i  input  1  synchronous clear.
REQ-010 load_i  input  1  synchronous load strobe.
REQ-011 load_val_i  input  WIDTH  value to load.
REQ-012 count_o  output  WIDTH  current count, driven directly from a register.
REQ-013 tc_o  output  1  registered single-cycle terminal-count pulse.
REQ-014 at_term_o  output  1  combinational flag: count_o equals the terminal value for the current up_i (MAX_COUNT when up, 0 when down).

Function
REQ-015 Priority per cycle SHALL be clr_i > load_i > counting step > hold.
REQ-016 clr_i: count_o <= 0 and prescaler <= 0 on the next edge; tc_o <= 0.
REQ-017 load_i (no clr_i): count_o <= min(load_val_i, MAX_COUNT), prescaler <= 0, tc_o <= 0.
REQ-018 Prescaler: counts 0..DIV-1 on cycles with en_i=1 and no clr/load; a tick SHALL occur in a cycle where en_i=1 and prescaler = DIV-1, and the prescaler returns to 0 on that cycle's edge; with DIV=1 every enabled cycle ticks.
REQ-019 Counting step: on a tick, count_o SHALL move by exactly 1 in the direction given by up_i sampled in that cycle.
REQ-020 Up at MAX_COUNT: MODE_WRAP goes to 0; MODE_SAT holds MAX_COUNT.
REQ-021 Down at 0: MODE_WRAP goes to MAX_COUNT; MODE_SAT holds 0.
REQ-022 tc_o SHALL be high for exactly the one cycle following a tick edge whose resulting count equals the terminal value for the up_i in effect at that tick; otherwise 0.
REQ-023 In MODE_SAT, a tick that holds at the boundary SHALL NOT re-assert tc_o.
REQ-024 A change of up_i between ticks SHALL take effect on the next tick, with no extra step or lost step.
REQ-025 Latency: count_o reflects a tick, clear or load one edge after the causing cycle.
REQ-026 en_i low during clr_i or load_i SHALL NOT block the clear or load.

Reset
REQ-027 rst_i high SHALL immediately, without a clock, force count_o=0, prescaler=0, tc_o=0.
REQ-028 Release of rst_i SHALL take effect on the following edge; the first tick SHALL occur after DIV enabled cycles.
REQ-029 Reset mid-count SHALL discard the partial prescaler state.

Structure
REQ-030 Package time_counter_pkg SHALL hold mode_e (MODE_WRAP, MODE_SAT).
REQ-031 The prescaler SHALL be a sub-module tick_gen (parameter DIV; ports clk_i, rst_i, en_i, sync_clr_i, tick_o); clr_i or load_i drives sync_clr_i.
REQ-032 For DIV=1, tick_gen SHALL reduce to tick_o = en_i with no register.

Verification
REQ-033 WIDTH=5, MAX=31, DIV=1, WRAP, up: 33 enabled cycles from reset -> count 0..31,0,1; tc_o high exactly once, the cycle after count reaches 31.
REQ-034 WIDTH=4, MAX=9, DIV=4, SAT, down: load 2, en high 16 cycles -> steps every 4 cycles 2,1,0,0,0; tc_o once on reaching 0.
REQ-035 load_val_i=15 with MAX=9 -> count_o=9; same cycle clr_i=1 -> count_o=0 (clear wins).
REQ-036 WRAP, count 5, toggle up_i each tick, DIV=1 -> 6,5,6,5; no tc_o; en_i low 3 cycles -> count frozen.
REQ-037 rst_i asserted mid-cycle while count=7, DIV=3, prescaler=2 -> count_o=0 before next edge; after release, first step after 3 enabled cycles.
